// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
//
// Produces same-cycle write enables and bubble (flush) controls for the
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from load-use, branch/jump
// redirect and data-memory wait conditions. A small FSM tracks memory waits
// and freezes the pipe in HALT when a wait exceeds MEM_TIMEOUT cycles.
//
// Optional feature macro: HAZARD_PERF_EN (adds saturating perf counters).
//
// Ports:
//   clk, reset           clock (rising edge), synchronous active-high reset
//   id_rs, id_rt         source register fields of the ID instruction
//   id_uses_rt           ID instruction reads rt
//   id_jump              ID holds J/JAL/JR/JALR
//   ex_memrd, ex_addrc   EX instruction is a load / its destination register
//   ex_branch_taken      branch in EX resolved taken
//   mem_req, mem_ready   data-memory access pending / completing this cycle
//   pc_we .. ex_mem_we   pipeline register write enables
//   *_flush              load a bubble into that pipeline register
//   state                00 RUN, 01 MEM_WAIT, 10 HALT
//   mem_timeout          sticky, set on entry to HALT
//   perf_*               (HAZARD_PERF_EN only) load-stall, flush, mem-stall counts
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 15,
`ifdef HAZARD_PERF_EN
   parameter int unsigned TO_W        = 4,
   parameter int unsigned CNT_W       = 16
`else
   parameter int unsigned TO_W        = 4
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_uses_rt,
   input  logic       id_jump,
   input  logic       ex_memrd,
   input  logic [4:0] ex_addrc,
   input  logic       ex_branch_taken,
   input  logic       mem_req,
   input  logic       mem_ready,
   output logic       pc_we,
   output logic       if_id_we,
   output logic       id_ex_we,
   output logic       ex_mem_we,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       mem_wb_flush,
   output logic [1:0] state,
   output logic       mem_timeout
`ifdef HAZARD_PERF_EN
   ,
   output logic [CNT_W-1:0] perf_load_stall,
   output logic [CNT_W-1:0] perf_flush,
   output logic [CNT_W-1:0] perf_mem_stall
`endif
);

   typedef enum logic [1:0] {
      StRun     = 2'b00,
      StMemWait = 2'b01,
      StHalt    = 2'b10
   } state_e;

   localparam logic [TO_W-1:0] TimeoutCnt = TO_W'(MEM_TIMEOUT);

   state_e          state_q, state_d;
   logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            timeout_q, timeout_d;

   logic memstall;
   logic loaduse;

   assign memstall = mem_req & ~mem_ready;
   assign loaduse  = ex_memrd & (ex_addrc != 5'd0) &
                     ((ex_addrc == id_rs) | (id_uses_rt & (ex_addrc == id_rt)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StRun;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      timeout_d  = timeout_q;
      unique case (state_q)
         StRun: begin
            if (memstall) begin
               state_d    = StMemWait;
               wait_cnt_d = {{(TO_W-1){1'b0}}, 1'b1};
            end
         end
         StMemWait: begin
            if (!memstall) begin
               state_d    = StRun;
               wait_cnt_d = '0;
            end else if (wait_cnt_q == TimeoutCnt) begin
               state_d   = StHalt;
               timeout_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         StHalt: ;
         default: begin
            state_d    = StRun;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Mealy outputs; HALT leaves everything frozen with no bubbles.
   always_comb begin
      pc_we        = 1'b0;
      if_id_we     = 1'b0;
      id_ex_we     = 1'b0;
      ex_mem_we    = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (reset) begin
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else if (state_q != StHalt) begin
         if (memstall) begin
            // Whole pipe frozen; only the completing MEM/WB slot gets a bubble.
            mem_wb_flush = 1'b1;
         end else if (ex_branch_taken) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (loaduse) begin
            id_ex_we    = 1'b1;
            ex_mem_we   = 1'b1;
            id_ex_flush = 1'b1;
         end else if (id_jump) begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
            if_id_flush = 1'b1;
         end else begin
            {pc_we, if_id_we, id_ex_we, ex_mem_we} = 4'b1111;
         end
      end
   end

   assign state       = state_q;
   assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_EN
   logic active;
   logic load_win, flush_win, mem_win;

   assign active    = ~reset & (state_q != StHalt);
   assign mem_win   = active & memstall;
   assign flush_win = active & ~memstall & (ex_branch_taken | (id_jump & ~loaduse));
   assign load_win  = active & ~memstall & ~ex_branch_taken & loaduse;

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_load_stall <= '0;
         perf_flush      <= '0;
         perf_mem_stall  <= '0;
      end else begin
         if (load_win && !(&perf_load_stall)) perf_load_stall <= perf_load_stall + 1'b1;
         if (flush_win && !(&perf_flush))     perf_flush      <= perf_flush + 1'b1;
         if (mem_win && !(&perf_mem_stall))   perf_mem_stall  <= perf_mem_stall + 1'b1;
      end
   end
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

   logic       clk;
   logic       reset;
   logic [4:0] id_rs, id_rt, ex_addrc;
   logic       id_uses_rt, id_jump, ex_memrd, ex_branch_taken, mem_req, mem_ready;
   logic       pc_we, if_id_we, id_ex_we, ex_mem_we;
   logic       if_id_flush, id_ex_flush, mem_wb_flush;
   logic [1:0] state;
   logic       mem_timeout;
`ifdef HAZARD_PERF_EN
   logic [15:0] perf_load_stall, perf_flush, perf_mem_stall;
`endif

   int total = 0;
   int bad   = 0;

   // {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush}
   logic [6:0] ctl;
   assign ctl = {pc_we, if_id_we, id_ex_we, ex_mem_we, if_id_flush, id_ex_flush, mem_wb_flush};

   localparam logic [6:0] C_RESET  = 7'b0000_111;
   localparam logic [6:0] C_NORMAL = 7'b1111_000;
   localparam logic [6:0] C_LU     = 7'b0011_010;
   localparam logic [6:0] C_BRANCH = 7'b1111_110;
   localparam logic [6:0] C_JUMP   = 7'b1111_100;
   localparam logic [6:0] C_FROZEN = 7'b0000_001;
   localparam logic [6:0] C_HALT   = 7'b0000_000;

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT (15),
`ifdef HAZARD_PERF_EN
      .TO_W        (4),
      .CNT_W       (16)
`else
      .TO_W        (4)
`endif
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .id_jump         (id_jump),
      .ex_memrd        (ex_memrd),
      .ex_addrc        (ex_addrc),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_we           (pc_we),
      .if_id_we        (if_id_we),
      .id_ex_we        (id_ex_we),
      .ex_mem_we       (ex_mem_we),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_flush    (mem_wb_flush),
      .state           (state),
      .mem_timeout     (mem_timeout)
`ifdef HAZARD_PERF_EN
      ,
      .perf_load_stall (perf_load_stall),
      .perf_flush      (perf_flush),
      .perf_mem_stall  (perf_mem_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_inputs();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_jump = 1'b0;
      ex_memrd = 1'b0; ex_addrc = 5'd0; ex_branch_taken = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; clear_inputs();
      mem_req = 1'b1; // memstall must not matter while reset is high
      @(negedge clk);
      total++; if (ctl !== C_RESET) begin bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
      tick();
      @(negedge clk);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", state); end
      total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
      reset = 1'b0; clear_inputs();
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL idle_ctl: got %b want %b", ctl, C_NORMAL); end
      tick();
   endtask

   task automatic test_load_use();
      clear_inputs(); ex_memrd = 1'b1; ex_addrc = 5'd5; id_rs = 5'd5;
      @(negedge clk);
      total++; if (ctl !== C_LU) begin bad++; $display("FAIL load_use_rs: got %b want %b", ctl, C_LU); end
      tick();
      total++; if (state !== 2'b00) begin bad++; $display("FAIL load_use_state: got %b want 00", state); end
      ex_memrd = 1'b0;
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL load_use_after: got %b want %b", ctl, C_NORMAL); end
      tick();
      // rt match only counts when the instruction actually reads rt
      clear_inputs(); ex_memrd = 1'b1; ex_addrc = 5'd8; id_rt = 5'd8; id_rs = 5'd3;
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL load_use_rt_unused: got %b want %b", ctl, C_NORMAL); end
      id_uses_rt = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      total++; if (ctl !== C_LU) begin bad++; $display("FAIL load_use_rt: got %b want %b", ctl, C_LU); end
      tick();
   endtask

   task automatic test_branch_jump();
      clear_inputs(); ex_memrd = 1'b1; ex_addrc = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
      ex_branch_taken = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL branch_vs_lu: got %b want %b", ctl, C_BRANCH); end
      tick();
      clear_inputs(); id_jump = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_JUMP) begin bad++; $display("FAIL jump: got %b want %b", ctl, C_JUMP); end
      tick();
      // load-use outranks a jump in ID
      ex_memrd = 1'b1; ex_addrc = 5'd12; id_rs = 5'd12;
      @(negedge clk);
      total++; if (ctl !== C_LU) begin bad++; $display("FAIL jump_vs_lu: got %b want %b", ctl, C_LU); end
      tick();
      clear_inputs(); ex_branch_taken = 1'b1; id_jump = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL branch_vs_jump: got %b want %b", ctl, C_BRANCH); end
      tick();
   endtask

   task automatic test_reg0();
      clear_inputs(); ex_memrd = 1'b1; ex_addrc = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL reg0: got %b want %b", ctl, C_NORMAL); end
      tick();
   endtask

   task automatic test_mem_same_cycle();
      clear_inputs(); mem_req = 1'b1; mem_ready = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL mem_ready_same_ctl: got %b want %b", ctl, C_NORMAL); end
      tick();
      total++; if (state !== 2'b00) begin bad++; $display("FAIL mem_ready_same_state: got %b want 00", state); end
   endtask

   task automatic test_mem_wait();
      logic [1:0] exp_state;
      clear_inputs(); mem_req = 1'b1; mem_ready = 1'b0;
      ex_branch_taken = 1'b1; // ignored while frozen
      for (int i = 0; i < 3; i++) begin
         exp_state = (i == 0) ? 2'b00 : 2'b01;
         @(negedge clk);
         total++; if (ctl !== C_FROZEN) begin bad++; $display("FAIL mem_wait_ctl[%0d]: got %b want %b", i, ctl, C_FROZEN); end
         total++; if (state !== exp_state) begin bad++; $display("FAIL mem_wait_state[%0d]: got %b want %b", i, state, exp_state); end
         tick();
      end
      ex_branch_taken = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL mem_wait_done_ctl: got %b want %b", ctl, C_NORMAL); end
      total++; if (state !== 2'b01) begin bad++; $display("FAIL mem_wait_done_state: got %b want 01", state); end
      tick();
      clear_inputs();
      @(negedge clk);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL mem_wait_back_run: got %b want 00", state); end
      total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL mem_wait_no_timeout: got %b want 0", mem_timeout); end
      tick();
   endtask

   task automatic test_timeout();
      logic [1:0] exp_state;
      clear_inputs(); mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) begin
         exp_state = (i == 0) ? 2'b00 : 2'b01;
         @(negedge clk);
         total++; if (ctl !== C_FROZEN || state !== exp_state) begin
            bad++; $display("FAIL timeout_frozen[%0d]: ctl=%b state=%b want %b/%b", i, ctl, state, C_FROZEN, exp_state);
         end
         tick();
      end
      @(negedge clk);
      total++; if (state !== 2'b10) begin bad++; $display("FAIL halt_state: got %b want 10", state); end
      total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL halt_timeout: got %b want 1", mem_timeout); end
      total++; if (ctl !== C_HALT) begin bad++; $display("FAIL halt_ctl: got %b want %b", ctl, C_HALT); end
      tick();
      // HALT ignores everything, even a completed access and a branch
      mem_ready = 1'b1; ex_branch_taken = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_HALT) begin bad++; $display("FAIL halt_hold_ctl: got %b want %b", ctl, C_HALT); end
      tick();
      total++; if (state !== 2'b10 || mem_timeout !== 1'b1) begin
         bad++; $display("FAIL halt_sticky: state=%b to=%b want 10/1", state, mem_timeout);
      end
      reset = 1'b1; clear_inputs();
      @(negedge clk);
      total++; if (ctl !== C_RESET) begin bad++; $display("FAIL halt_reset_ctl: got %b want %b", ctl, C_RESET); end
      tick();
      reset = 1'b0;
      @(negedge clk);
      total++; if (state !== 2'b00 || mem_timeout !== 1'b0) begin
         bad++; $display("FAIL halt_reset_state: state=%b to=%b want 00/0", state, mem_timeout);
      end
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL halt_reset_idle: got %b want %b", ctl, C_NORMAL); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      clear_inputs(); mem_req = 1'b1;
      tick(); tick();
      total++; if (state !== 2'b01) begin bad++; $display("FAIL rst_wait_enter: got %b want 01", state); end
      reset = 1'b1;
      tick();
      reset = 1'b0; clear_inputs();
      @(negedge clk);
      total++; if (state !== 2'b00) begin bad++; $display("FAIL rst_wait_state: got %b want 00", state); end
      tick();
   endtask

   task automatic test_back_to_back();
      // load-use, branch, jump, normal on consecutive cycles
      clear_inputs(); ex_memrd = 1'b1; ex_addrc = 5'd7; id_rs = 5'd7;
      @(negedge clk);
      total++; if (ctl !== C_LU) begin bad++; $display("FAIL b2b_lu: got %b want %b", ctl, C_LU); end
      tick();
      clear_inputs(); ex_branch_taken = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL b2b_branch: got %b want %b", ctl, C_BRANCH); end
      tick();
      clear_inputs(); id_jump = 1'b1;
      @(negedge clk);
      total++; if (ctl !== C_JUMP) begin bad++; $display("FAIL b2b_jump: got %b want %b", ctl, C_JUMP); end
      tick();
      clear_inputs();
      @(negedge clk);
      total++; if (ctl !== C_NORMAL) begin bad++; $display("FAIL b2b_normal: got %b want %b", ctl, C_NORMAL); end
      tick();
   endtask

`ifdef HAZARD_PERF_EN
   task automatic test_perf();
      reset = 1'b1; clear_inputs(); tick(); reset = 1'b0;
      total++; if (perf_load_stall !== 16'd0 || perf_flush !== 16'd0 || perf_mem_stall !== 16'd0) begin
         bad++; $display("FAIL perf_clear: %0d/%0d/%0d want 0/0/0", perf_load_stall, perf_flush, perf_mem_stall);
      end
      ex_memrd = 1'b1; ex_addrc = 5'd4; id_rs = 5'd4;
      tick(); tick();
      clear_inputs(); ex_branch_taken = 1'b1;
      tick();
      clear_inputs(); mem_req = 1'b1;
      tick(); tick(); tick(); tick();
      clear_inputs();
      tick();
      total++; if (perf_load_stall !== 16'd2 || perf_flush !== 16'd1 || perf_mem_stall !== 16'd4) begin
         bad++; $display("FAIL perf_counts: %0d/%0d/%0d want 2/1/4", perf_load_stall, perf_flush, perf_mem_stall);
      end
   endtask
`endif

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_load_use();
      test_branch_jump();
      test_reg0();
      test_mem_same_cycle();
      test_mem_wait();
      test_timeout();
      test_reset_in_wait();
      test_back_to_back();
`ifdef HAZARD_PERF_EN
      test_perf();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Stall/flush controller for the 5-stage pipeline; drives write-enable and flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards, branch/jump redirects and multi-cycle data-memory waits; detects memory timeouts and halts.
- Sits beside the pipeline registers in the CPU top; outputs are same-cycle (Mealy) from a small FSM plus hazard compare logic.

Parameters:
- MEM_TIMEOUT, 15: max consecutive MEM_WAIT cycles before entering HALT.
- TO_W, 4: width of the wait counter; must satisfy 2^TO_W > MEM_TIMEOUT.
- CNT_W, 16: width of the performance counters (optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_rs  in  5  rs field of instruction in ID.
- id_rt  in  5  rt field of instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt.
- id_jump  in  1  ID holds J/JAL/JR/JALR.
- ex_memrd  in  1  MemRd of instruction in EX (ID/EX output).
- ex_addrc  in  5  destination register of instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  EX/MEM MemRd_out | MemWr_out.
- mem_ready  in  1  data memory completes access this cycle.
- pc_we, if_id_we, id_ex_we, ex_mem_we  out  1 each  register write enables.
- if_id_flush, id_ex_flush, mem_wb_flush  out  1 each  load bubble (zero controls) into that register.
- state  out  2  00 RUN, 01 MEM_WAIT, 10 HALT.
- mem_timeout  out  1  sticky; set on entry to HALT.

Behaviour:
- Reset (reset=1 at edge): state<=RUN, wait_cnt<=0, mem_timeout<=0. While reset is high, all *_we=0 and all *_flush=1, regardless of state.
- Hazard terms (combinational):
  - memstall = mem_req & ~mem_ready.
  - loaduse = ex_memrd & (ex_addrc!=0) & ((ex_addrc==id_rs) | (id_uses_rt & ex_addrc==id_rt)).
- Output priority in RUN/MEM_WAIT (highest first):
  1. memstall: pc_we=if_id_we=id_ex_we=ex_mem_we=0, mem_wb_flush=1, other flushes=0. Freezes the whole pipe; branch and loaduse are ignored this cycle and re-evaluated when the stall ends.
  2. ex_branch_taken: all we=1, if_id_flush=1, id_ex_flush=1. Overrides loaduse and id_jump.
  3. loaduse: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_flush=1, ex_mem_we=1. Exactly one bubble per load-use pair.
  4. id_jump: all we=1, if_id_flush=1.
  5. Otherwise: all we=1, all flush=0.
- FSM transitions (at clk edge):
  - RUN->MEM_WAIT on memstall; wait_cnt<=1.
  - MEM_WAIT->RUN when mem_ready=1 or mem_req=0; wait_cnt<=0.
  - MEM_WAIT stays while memstall and wait_cnt<MEM_TIMEOUT; wait_cnt increments.
  - MEM_WAIT->HALT when memstall and wait_cnt==MEM_TIMEOUT; mem_timeout<=1.
  - HALT: terminal until reset; all we=0, all flush=0 (pipeline frozen for debug).
- Boundaries:
  - mem_ready arriving the same cycle as mem_req produces no stall and no state change.
  - Total stall before HALT is exactly MEM_TIMEOUT+1 frozen cycles.
  - ex_addrc=0 never causes loaduse.
  - Reset asserted in MEM_WAIT or HALT returns to RUN at the next edge.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs perf_load_stall, perf_flush, perf_mem_stall (CNT_W each).
  - Counters increment on cycles where loaduse wins, where branch/jump flush wins, and where memstall holds, respectively.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_memrd=1, ex_addrc=5, id_rs=5, others 0 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; the next cycle (ex_memrd=0) all we=1.
- Branch vs load-use: ex_branch_taken=1 with a load-use match on rt=8 -> if_id_flush=id_ex_flush=1, pc_we=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 -> state 01 for 3 cycles with all we=0 and mem_wb_flush=1, then RUN with no timeout.
- Timeout: MEM_TIMEOUT=15, mem_ready held 0 -> after 16 frozen cycles state=10, mem_timeout=1, all outputs frozen; reset pulse -> state=00, mem_timeout=0.
- Register 0: ex_memrd=1, ex_addrc=0, id_rs=0 -> no stall, all we=1.
- HAZARD_PERF_EN: 2 load-use stalls, 1 branch, 4 memstall cycles -> counters read 2/1/4.
